convlayer1_ctrl: RTL

Sequencer for the first convolution layer (conv + ReLU + maxpool, CO channels). On a start pulse it clears the layer, streams one IF_SIZE×IF_SIZE input image from the feature-map memory into the layer with correctly aligned clock-enables, and collects every pooled output vector into the result buffer. It then reports completion, or an error if the pooled output count is wrong or the output stream stalls. It sits between the top-level network scheduler and the convlayer1 datapath.

---
 rtl/convlayer1_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/convlayer1_ctrl.sv
// Frame sequencer for convolution layer 1: clears the layer, streams one image from
// feature-map memory with aligned clock-enables, and collects pooled outputs into the result buffer.
module convlayer1_ctrl #(
    parameter int IF_SIZE  = 28,
    parameter int K_SIZE   = 5,
    parameter int P_SIZE   = 2,
    parameter int I_BW     = 16,
    parameter int CO       = 3,
    parameter int O_BW     = 16,
    parameter int FADDR_BW = 10,
    parameter int OADDR_BW = 8,
    parameter int DRAIN_TO = 64
) (
    input  logic                 clk,
    input  logic                 global_rst_n,
    input  logic                 i_start,
    input  logic                 i_pause,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err,
    output logic                 o_mem_rd_en,
    output logic [FADDR_BW-1:0]  o_mem_addr,
    input  logic [I_BW-1:0]      i_mem_data,
    output logic                 o_layer_rst,
    output logic                 o_layer_ce,
    output logic [I_BW-1:0]      o_layer_fmap,
    input  logic                 i_valid_max,
    input  logic                 i_end_max,
    input  logic [CO*O_BW-1:0]   i_result,
    output logic                 o_wr_en,
    output logic [OADDR_BW-1:0]  o_wr_addr,
    output logic [CO*O_BW-1:0]   o_wr_data
);

    localparam int NPIX    = IF_SIZE * IF_SIZE;
    localparam int POOL_SD = (IF_SIZE - K_SIZE + 1) / P_SIZE;
    localparam int NPOOL   = POOL_SD * POOL_SD;
    localparam int OCNT_BW = OADDR_BW + 1;
    localparam int WD_BW   = $clog2(DRAIN_TO + 1);

    localparam logic [FADDR_BW-1:0] LAST_PIX  = FADDR_BW'(NPIX - 1);
    localparam logic [OCNT_BW-1:0]  NPOOL_C   = OCNT_BW'(NPOOL);
    localparam logic [OCNT_BW-1:0]  LAST_OUT  = OCNT_BW'(NPOOL - 1);
    localparam logic [WD_BW-1:0]    WD_LIMIT  = WD_BW'(DRAIN_TO - 1);
    localparam logic [WD_BW-1:0]    WD_ONE    = WD_BW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_r, state_s;
    logic                   clr_cnt_r;
    logic [FADDR_BW-1:0]    pix_cnt_r;
    logic [OCNT_BW-1:0]     out_cnt_r;
    logic [WD_BW-1:0]       wd_r;
    logic                   final_r;
    logic                   rd_d1_r;
    logic                   ce_r;
    logic [I_BW-1:0]        fmap_r;
    logic                   layer_rst_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   err_r;
    logic                   wr_en_r;
    logic [OADDR_BW-1:0]    wr_addr_r;
    logic [CO*O_BW-1:0]     wr_data_r;

    logic start_acc_s, rd_en_s, capture_s, in_range_s, last_s;
    logic write_s, hit_end_s, wd_exp_s, err_set_s;

    // Per-cycle decode of reads, captures, exit and error events
    always_comb begin
        start_acc_s = (state_r == S_IDLE) && i_start;
        rd_en_s     = (state_r == S_FEED) && !i_pause;
        capture_s   = i_valid_max && ((state_r == S_FEED) || (state_r == S_DRAIN));
        in_range_s  = (out_cnt_r < NPOOL_C);
        last_s      = (out_cnt_r == LAST_OUT);
        write_s     = capture_s && in_range_s;
        hit_end_s   = write_s && (last_s || i_end_max);
        wd_exp_s    = (state_r == S_DRAIN) && !i_valid_max && (wd_r == WD_LIMIT);
        // Overflow, missing end flag on the last output, early end flag, or a stalled drain
        err_set_s   = (capture_s && (!in_range_s || (last_s != i_end_max))) || wd_exp_s;
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:  if (i_start) state_s = S_CLR; else state_s = S_IDLE;
            S_CLR:   if (clr_cnt_r) state_s = S_FEED; else state_s = S_CLR;
            S_FEED:  if (rd_en_s && (pix_cnt_r == LAST_PIX)) state_s = S_DRAIN; else state_s = S_FEED;
            S_DRAIN: if (final_r || hit_end_s || wd_exp_s) state_s = S_DONE; else state_s = S_DRAIN;
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State, counters and status flags
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state_r     <= S_IDLE;
            clr_cnt_r   <= 1'b0;
            pix_cnt_r   <= '0;
            out_cnt_r   <= '0;
            wd_r        <= WD_ONE;
            final_r     <= 1'b0;
            err_r       <= 1'b0;
            layer_rst_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            clr_cnt_r   <= (state_r == S_CLR) ? ~clr_cnt_r : 1'b0;
            if (start_acc_s) begin
                pix_cnt_r <= '0;
                out_cnt_r <= '0;
                final_r   <= 1'b0;
                err_r     <= 1'b0;
            end else begin
                if (rd_en_s)   pix_cnt_r <= pix_cnt_r + FADDR_BW'(1);
                if (write_s)   out_cnt_r <= out_cnt_r + OCNT_BW'(1);
                if (hit_end_s) final_r   <= 1'b1;
                if (err_set_s) err_r     <= 1'b1;
            end
            // wd_r counts cycles since the last pooled output, the output cycle itself being 0
            if ((state_r != S_DRAIN) || i_valid_max) wd_r <= WD_ONE;
            else if (wd_r != WD_LIMIT)               wd_r <= wd_r + WD_ONE;
            layer_rst_r <= (state_s == S_CLR);
            busy_r      <= (state_s != S_IDLE);
            done_r      <= (state_s == S_DONE);
        end
    end

    // Read-to-ce pipeline and result-buffer write port
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            rd_d1_r   <= 1'b0;
            ce_r      <= 1'b0;
            fmap_r    <= '0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= '0;
        end else begin
            rd_d1_r <= rd_en_s;
            ce_r    <= rd_d1_r;
            if (rd_d1_r) fmap_r <= i_mem_data;
            wr_en_r <= write_s;
            if (write_s) begin
                wr_addr_r <= out_cnt_r[OADDR_BW-1:0];
                wr_data_r <= i_result;
            end
        end
    end

    assign o_busy       = busy_r;
    assign o_done       = done_r;
    assign o_err        = err_r;
    assign o_mem_rd_en  = rd_en_s;
    assign o_mem_addr   = pix_cnt_r;
    assign o_layer_rst  = layer_rst_r;
    assign o_layer_ce   = ce_r;
    assign o_layer_fmap = fmap_r;
    assign o_wr_en      = wr_en_r;
    assign o_wr_addr    = wr_addr_r;
    assign o_wr_data    = wr_data_r;

endmodule
